masked_sum_sequencer: RTL and testbench

MASKED_SUM_SEQUENCER -- requirements
Module: masked_sum_sequencer

---
 rtl/masked_sum_sequencer.sv | 119 +++++++++++
 tb/tb_masked_sum_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/masked_sum_sequencer.sv
// Purpose : sums the mask-enabled signed lanes of one frame, one lane per cycle, and reports sum, lane count and result width.
// Latency : frame accepted at edge k -> out_valid first high after edge k+NUM_INPUT+1 (mask does not change timing).
// Backpressure: one frame in flight; in_ready only in IDLE; result held in DONE until out_valid&&out_ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     frame handshake; in_data carries NUM_INPUT signed lanes, in_mask enables lanes
//   out_valid/out_ready   result handshake
//   out_sum               signed sum of enabled lanes (SUM_W bits, cannot overflow)
//   out_count             number of enabled lanes
//   out_width             ORI_WIDTH plus growth bits needed for out_count lanes
//   busy                  frame in ACCUM or DONE
module masked_sum_sequencer #(
    parameter  int NUM_INPUT = 8,
    parameter  int ORI_WIDTH = 16,
    localparam int SUM_W     = ORI_WIDTH + $clog2(NUM_INPUT),
    localparam int CNT_W     = $clog2(NUM_INPUT + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_INPUT*ORI_WIDTH-1:0] in_data,
    input  logic [NUM_INPUT-1:0]           in_mask,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [SUM_W-1:0]        out_sum,
    output logic [CNT_W-1:0]               out_count,
    output logic [7:0]                     out_width,
    output logic                           busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [CNT_W-1:0] LANES = CNT_W'(NUM_INPUT);

    state_t                         state;
    logic [NUM_INPUT*ORI_WIDTH-1:0] data_q;
    logic [NUM_INPUT-1:0]           mask_q;
    logic [CNT_W-1:0]               idx;
    logic [CNT_W-1:0]               cnt;
    logic signed [SUM_W-1:0]        acc;
    logic signed [SUM_W-1:0]        lane_ext;

    // The frame is shifted down one lane per cycle, so the current lane is always the bottom slice.
    assign lane_ext = {{(SUM_W-ORI_WIDTH){data_q[ORI_WIDTH-1]}}, data_q[ORI_WIDTH-1:0]};

    // ORI_WIDTH + g, where g = 0 for count<=1, else the smallest g with 2^g >= count.
    function automatic logic [7:0] width_of(input logic [CNT_W-1:0] c);
        int g;
        g = 0;
        for (int i = 0; i < CNT_W; i++) begin
            if ((1 << g) < int'(c)) g = g + 1;
        end
        return 8'(ORI_WIDTH + g);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_width <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            idx       <= '0;
            cnt       <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_data;
                        mask_q   <= in_mask;
                        acc      <= '0;
                        cnt      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (idx == LANES) begin
                        // All lanes consumed; this cycle publishes the result and its width.
                        out_sum   <= acc;
                        out_count <= cnt;
                        out_width <= width_of(cnt);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        if (mask_q[0]) begin
                            acc <= acc + lane_ext;
                            cnt <= cnt + CNT_W'(1);
                        end
                        data_q <= data_q >> ORI_WIDTH;
                        mask_q <= mask_q >> 1;
                        idx    <= idx + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_masked_sum_sequencer.sv
module tb_masked_sum_sequencer;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int SW = 19;
    localparam int CW = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [N*W-1:0]        in_data;
    logic [N-1:0]          in_mask;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [SW-1:0]  out_sum;
    logic [CW-1:0]         out_count;
    logic [7:0]            out_width;
    logic                  busy;

    int n_chk  = 0;
    int n_pass = 0;

    masked_sum_sequencer #(.NUM_INPUT(N), .ORI_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_width (out_width),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = 16'($urandom);
        return d;
    endfunction

    // Reference: plain arithmetic over the enabled lanes.
    task automatic model(input logic [N*W-1:0] d, input logic [N-1:0] m,
                         output longint s, output int c, output int w);
        logic signed [W-1:0] lane;
        s = 0;
        c = 0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                lane = d[i*W +: W];
                s = s + longint'(lane);
                c = c + 1;
            end
        end
        w = (c <= 1) ? W : W + $clog2(c);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic run_frame(input string tag, input logic [N*W-1:0] d, input logic [N-1:0] m, input int hold);
        longint es;
        int     ec, ew, seen;
        model(d, m, es, ec, ew);
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = rand_data();
        in_mask  = 8'($urandom);
        chk({tag, "_busy_accum"}, busy, 1);
        chk({tag, "_in_ready_accum"}, in_ready, 0);
        seen = -1;
        for (int e = 1; e <= 20 && seen < 0; e++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = e;
        end
        chk({tag, "_latency"}, seen, N + 1);
        chk({tag, "_sum"}, out_sum, es);
        chk({tag, "_count"}, out_count, ec);
        chk({tag, "_width"}, out_width, ew);
        chk({tag, "_in_ready_done"}, in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            in_data  = rand_data();
            in_mask  = 8'($urandom);
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_sum"}, out_sum, es);
            chk({tag, "_hold_count"}, out_count, ec);
            chk({tag, "_hold_width"}, out_width, ew);
            chk({tag, "_hold_in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_release_valid"}, out_valid, 0);
        chk({tag, "_release_in_ready"}, in_ready, 1);
        chk({tag, "_release_busy"}, busy, 0);
        chk({tag, "_idle_sum_held"}, out_sum, es);
        chk({tag, "_idle_width_held"}, out_width, ew);
    endtask

    initial begin
        logic [N*W-1:0] d;
        int             saw_valid;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mask   = '0;
        out_ready = 1'b0;
        #22;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_count", out_count, 0);
        chk("rst_width", out_width, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        // All lanes full-scale positive.
        for (int i = 0; i < N; i++) d[i*W +: W] = 16'h7FFF;
        run_frame("full_pos", d, 8'hFF, 0);

        // All lanes full-scale negative (no overflow).
        for (int i = 0; i < N; i++) d[i*W +: W] = 16'h8000;
        run_frame("full_neg", d, 8'hFF, 1);

        // Two negative lanes.
        for (int i = 0; i < N; i++) d[i*W +: W] = 16'h1234;
        d[0*W +: W] = 16'hFFFF;
        d[2*W +: W] = 16'h8000;
        run_frame("mask05", d, 8'h05, 0);

        // Empty mask.
        run_frame("mask00", rand_data(), 8'h00, 0);

        // Five lanes of 1 with stalled consumer.
        for (int i = 0; i < N; i++) d[i*W +: W] = 16'h0001;
        run_frame("mask1f", d, 8'h1F, 3);

        // Single lane.
        d = rand_data();
        d[0*W +: W] = 16'h0003;
        run_frame("mask01", d, 8'h01, 0);

        // Reset in the middle of accumulation.
        wait_ready();
        in_valid = 1'b1;
        in_data  = rand_data();
        in_mask  = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_sum", out_sum, 0);
        chk("midrst_count", out_count, 0);
        chk("midrst_width", out_width, 0);
        #2;
        rst_n = 1'b1;
        saw_valid = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1;
        end
        chk("midrst_no_result", saw_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        run_frame("after_rst", rand_data(), 8'($urandom), 0);

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            logic [N-1:0] m;
            m = 8'($urandom);
            if (f % 7 == 0) m = 8'h00;
            if (f % 7 == 1) m = 8'hFF;
            run_frame($sformatf("rnd%0d", f), rand_data(), m, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
